cu_fetch_sequencer: RTL
=======================

Name: cu_fetch_sequencer

Overview:
- Sequencing front end of the control unit; sits directly upstream of the instruction-group decoders.
- Runs the instruction fetch: drives the fetch control word, latches IR from the memory data bus, then presents IR and the current execute step (state) to the decoders.
- Passes the selected decoder's control word to the datapath and follows the decoder's NS until the instruction retires.
- Owns the status-flag register, a retired-instruction counter and a sticky fault detector.

Parameters:
- CUL, 36, MSB index of controlWord; the vector is CUL+1 bits wide.
- MAX_WAIT, 15, maximum FETCH cycles waiting for mem_ready before fault.
- MAX_EXEC, 8, maximum EXEC cycles per instruction before fault.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- mem_data  in  32  instruction word from the memory data bus.
- mem_ready  in  1  memory has valid read data this cycle.
- exec_cw  in  CUL+1  control word from the selected instruction-group decoder.
- exec_NS  in  3  next execute step from the decoder; 0 = last step.
- status_in  in  4  ALU flags {V,C,N,Z}.
- IR  out  32  instruction register.
- state  out  4  current execute step fed to the decoders.
- status  out  4  registered flags.
- controlWord  out  CUL+1  control word to the datapath.
- fetching  out  1  high while in FETCH.
- fault  out  1  sticky fault flag.
- retired  out  16  retired-instruction count.

Behaviour:
- controlWord bit map:
  - FS[35:31], SA[30:26], SB[25:21], DA[20:16]
  - w_reg[15], C0[14], B_Sel[13], mem_cs[12:11], mem_write_en[10]
  - IR_load[9], status_load[8], size[7:6], add_tri_sel[5]
  - data_tri_sel[4:3], PC_sel[2], PC_FS[1:0]
  - Bit 36 is always 0.
- FSM states: FETCH, EXEC, FAULT. Reset enters FETCH.
- Reset values: IR=0, state=0, status=0, retired=0, fault=0, wait counter=0, exec counter=0.
- FETCH controlWord:
  - Fixed fields: mem_cs=01, size=10 (32-bit), add_tri_sel=1 (PC drives address), data_tri_sel=00.
  - IR_load=mem_ready; PC_FS=01 (PC+4) when mem_ready, else 00 (hold).
  - All other fields 0. fetching=1.
- FETCH with mem_ready=1:
  - IR<=mem_data, state<=0, wait counter<=0; next state EXEC.
  - Minimum fetch latency is 1 cycle.
- FETCH with mem_ready=0:
  - Wait counter increments.
  - When the counter already equals MAX_WAIT, go to FAULT instead.
- EXEC:
  - controlWord=exec_cw, passed through combinationally.
  - status<=status_in when exec_cw[8]=1; otherwise status holds.
- EXEC with exec_NS==0:
  - Instruction retires: retired<=retired+1 (wraps 0xFFFF->0), state<=0, exec counter<=0; next state FETCH.
- EXEC with exec_NS!=0:
  - state<={1'b0,exec_NS}; exec counter increments; stay in EXEC.
  - When the exec counter already equals MAX_EXEC-1, go to FAULT instead.
- FAULT:
  - controlWord=0 (no register write, no memory write, PC hold). fault=1.
  - IR, status, state and retired hold.
  - Leaves only on reset.
- Single-state instruction with mem_ready tied high takes 2 cycles (FETCH, EXEC).
- Reset mid-operation (any state, any counter value): all registers return to reset values on that edge; the next cycle is FETCH.
- mem_data and mem_ready are ignored outside FETCH.

Test Plan:
- Reset, then mem_ready=1, mem_data=0xF8400020, exec_NS=0 -> IR=0xF8400020 one cycle after FETCH; next cycle EXEC with controlWord==exec_cw; retired 0->1; back to FETCH.
- mem_ready low for 3 cycles, then high -> fetching stays 1 for 4 cycles; PC_FS=00 for the first 3 cycles, 01 on the 4th; IR loads on the 4th edge.
- mem_ready held low -> fault=1 after exactly MAX_WAIT+1 FETCH cycles (16); controlWord=0; fault persists until reset, then FETCH resumes.
- Multi-step instruction with exec_NS sequence 2, 3, 0 -> state shows 0, 2, 3 on consecutive EXEC cycles; retired increments once; then FETCH.
- exec_cw with bit 8 set and status_in=0b1010 -> status=0b1010 on the next edge; with bit 8 clear and status_in=0b0101 -> status holds 0b1010.
- Assert reset during an EXEC cycle with state=2 -> next cycle FETCH with IR=0, state=0, retired=0, fault=0; preload retired=0xFFFF and retire one instruction -> retired=0x0000.

Source files
------------

// File: rtl/cu_fetch_sequencer.sv
// cu_fetch_sequencer: control-unit front end that fetches into IR, then steps the
// selected decoder through EXEC until NS==0, with status, retire count and sticky fault.
module cu_fetch_sequencer #(
    parameter int CUL      = 36,
    parameter int MAX_WAIT = 15,
    parameter int MAX_EXEC = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [31:0]    mem_data,
    input  logic           mem_ready,
    input  logic [CUL:0]   exec_cw,
    input  logic [2:0]     exec_NS,
    input  logic [3:0]     status_in,
    output logic [31:0]    IR,
    output logic [3:0]     state,
    output logic [3:0]     status,
    output logic [CUL:0]   controlWord,
    output logic           fetching,
    output logic           fault,
    output logic [15:0]    retired
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int EW = $clog2(MAX_EXEC + 1);

    typedef enum logic [1:0] {FETCH, EXEC, FAULT} phase_t;

    phase_t        cur, nxt;
    logic [WW-1:0] wait_cnt;
    logic [EW-1:0] exec_cnt;

    always_comb begin
        nxt         = cur;
        controlWord = '0;
        fetching    = 1'b0;
        fault       = 1'b0;
        case (cur)
            FETCH: begin
                fetching           = 1'b1;
                controlWord[12:11] = 2'b01;
                controlWord[9]     = mem_ready;
                controlWord[7:6]   = 2'b10;
                controlWord[5]     = 1'b1;
                controlWord[1:0]   = {1'b0, mem_ready};
                nxt = mem_ready ? EXEC : (wait_cnt == WW'(MAX_WAIT)) ? FAULT : FETCH;
            end
            EXEC: begin
                controlWord      = exec_cw;
                controlWord[CUL] = 1'b0;
                nxt = (exec_NS == 3'd0) ? FETCH : (exec_cnt == EW'(MAX_EXEC - 1)) ? FAULT : EXEC;
            end
            FAULT: fault = 1'b1;
            default: nxt = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cur      <= FETCH;
            IR       <= '0;
            state    <= '0;
            status   <= '0;
            retired  <= '0;
            wait_cnt <= '0;
            exec_cnt <= '0;
        end else begin
            cur <= nxt;
            case (cur)
                FETCH: begin
                    if (mem_ready) begin
                        IR       <= mem_data;
                        state    <= '0;
                        wait_cnt <= '0;
                    end else if (nxt == FETCH) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_cw[8])
                        status <= status_in;
                    if (exec_NS == 3'd0) begin
                        retired  <= retired + 16'd1;
                        state    <= '0;
                        exec_cnt <= '0;
                    end else if (nxt == EXEC) begin
                        state    <= {1'b0, exec_NS};
                        exec_cnt <= exec_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
